// File: rtl/lsu_dtcm_master.sv
// Single-outstanding load/store unit master for the DTCM: aligns and replicates
// store lanes, extracts and extends load data, and flags misaligned accesses.
module lsu_dtcm_master #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic              clk,
  input  logic              rst,
  // AGU request
  input  logic              agu_req_valid,
  output logic              agu_req_ready,
  input  logic              agu_req_load,
  input  logic [1:0]        agu_req_size,
  input  logic              agu_req_usign,
  input  logic [AW-1:0]     agu_req_addr,
  input  logic [DW-1:0]     agu_req_wdata,
  input  logic [4:0]        agu_req_rd,
  // write-back
  output logic              lsu_wb_valid,
  input  logic              lsu_wb_ready,
  output logic [DW-1:0]     lsu_wb_data,
  output logic [4:0]        lsu_wb_rd,
  output logic              lsu_wb_err,
  // DTCM command
  output logic              lsu2dtcm_cmd_valid,
  input  logic              lsu2dtcm_cmd_ready,
  output logic              lsu2dtcm_cmd_read,
  output logic [AW-1:0]     lsu2dtcm_cmd_addr,
  output logic [DW-1:0]     lsu2dtcm_cmd_wdata,
  output logic [DW/8-1:0]   lsu2dtcm_cmd_wmask,
  // DTCM response
  input  logic              lsu2dtcm_rsp_valid,
  output logic              lsu2dtcm_rsp_ready,
  input  logic [DW-1:0]     lsu2dtcm_rsp_rdata,
  output logic              lsu_busy
);

  localparam int unsigned MW = DW / 8;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RSP, S_WB} state_e;

  state_e          state_q, state_d;

  logic            req_load_q, req_load_d;
  logic [1:0]      req_size_q, req_size_d;
  logic            req_usign_q, req_usign_d;
  logic [1:0]      req_off_q, req_off_d;
  logic [4:0]      req_rd_q, req_rd_d;

  logic            cmd_read_q, cmd_read_d;
  logic [AW-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DW-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [MW-1:0]   cmd_wmask_q, cmd_wmask_d;

  logic [DW-1:0]   wb_data_q, wb_data_d;
  logic            wb_err_q, wb_err_d;

  logic            ready_q, cmd_valid_q, rsp_ready_q, wb_valid_q, busy_q;

  logic            accept_c;
  logic            misaligned_c;
  logic [DW-1:0]   st_wdata_c;
  logic [MW-1:0]   st_wmask_c;
  logic [15:0]     lane_c;
  logic [DW-1:0]   load_data_c;

  // ready_q is low during the reset cycle, so it gates acceptance instead of the state
  assign accept_c     = agu_req_valid & ready_q;
  assign misaligned_c = ((agu_req_size == 2'b01) & agu_req_addr[0]) |
                        (agu_req_size[1] & (agu_req_addr[1:0] != 2'b00));

  // Store lane replication/byte enables and load lane extraction
  always_comb begin
    st_wdata_c  = agu_req_wdata;
    st_wmask_c  = '1;
    case (agu_req_size)
      2'b00: begin
        st_wdata_c = {MW{agu_req_wdata[7:0]}};
        st_wmask_c = MW'(1) << agu_req_addr[1:0];
      end
      2'b01: begin
        st_wdata_c = {(DW/16){agu_req_wdata[15:0]}};
        st_wmask_c = MW'(3) << agu_req_addr[1:0];
      end
      default: begin
        st_wdata_c = agu_req_wdata;
        st_wmask_c = '1;
      end
    endcase

    lane_c      = 16'(lsu2dtcm_rsp_rdata >> {req_off_q, 3'b000});
    load_data_c = lsu2dtcm_rsp_rdata;
    case (req_size_q)
      2'b00:   load_data_c = {{(DW-8){~req_usign_q & lane_c[7]}}, lane_c[7:0]};
      2'b01:   load_data_c = {{(DW-16){~req_usign_q & lane_c[15]}}, lane_c[15:0]};
      default: load_data_c = lsu2dtcm_rsp_rdata;
    endcase
  end

  // Next-state and register-input logic
  always_comb begin
    state_d     = state_q;
    req_load_d  = req_load_q;
    req_size_d  = req_size_q;
    req_usign_d = req_usign_q;
    req_off_d   = req_off_q;
    req_rd_d    = req_rd_q;
    cmd_read_d  = cmd_read_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_wmask_d = cmd_wmask_q;
    wb_data_d   = wb_data_q;
    wb_err_d    = wb_err_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          req_load_d  = agu_req_load;
          req_size_d  = agu_req_size;
          req_usign_d = agu_req_usign;
          req_off_d   = agu_req_addr[1:0];
          req_rd_d    = agu_req_rd;
          if (misaligned_c) begin
            wb_data_d = '0;
            wb_err_d  = 1'b1;
            state_d   = S_WB;
          end else begin
            cmd_read_d  = agu_req_load;
            cmd_addr_d  = {agu_req_addr[AW-1:2], 2'b00};
            cmd_wdata_d = st_wdata_c;
            cmd_wmask_d = agu_req_load ? '0 : st_wmask_c;
            state_d     = S_CMD;
          end
        end
      end
      S_CMD: begin
        if (lsu2dtcm_cmd_ready) state_d = S_RSP;
      end
      S_RSP: begin
        // write responses are awaited too, but carry no data
        if (lsu2dtcm_rsp_valid) begin
          wb_data_d = req_load_q ? load_data_c : '0;
          wb_err_d  = 1'b0;
          state_d   = S_WB;
        end
      end
      S_WB: begin
        if (lsu_wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and handshake-output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_load_q  <= 1'b0;
      req_size_q  <= 2'b00;
      req_usign_q <= 1'b0;
      req_off_q   <= 2'b00;
      req_rd_q    <= 5'd0;
      cmd_read_q  <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_wmask_q <= '0;
      wb_data_q   <= '0;
      wb_err_q    <= 1'b0;
      ready_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      rsp_ready_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_load_q  <= req_load_d;
      req_size_q  <= req_size_d;
      req_usign_q <= req_usign_d;
      req_off_q   <= req_off_d;
      req_rd_q    <= req_rd_d;
      cmd_read_q  <= cmd_read_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_wmask_q <= cmd_wmask_d;
      wb_data_q   <= wb_data_d;
      wb_err_q    <= wb_err_d;
      ready_q     <= (state_d == S_IDLE);
      cmd_valid_q <= (state_d == S_CMD);
      rsp_ready_q <= (state_d == S_RSP);
      wb_valid_q  <= (state_d == S_WB);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign agu_req_ready      = ready_q;
  assign lsu_wb_valid       = wb_valid_q;
  assign lsu_wb_data        = wb_data_q;
  assign lsu_wb_rd          = req_rd_q;
  assign lsu_wb_err         = wb_err_q;
  assign lsu2dtcm_cmd_valid = cmd_valid_q;
  assign lsu2dtcm_cmd_read  = cmd_read_q;
  assign lsu2dtcm_cmd_addr  = cmd_addr_q;
  assign lsu2dtcm_cmd_wdata = cmd_wdata_q;
  assign lsu2dtcm_cmd_wmask = cmd_wmask_q;
  assign lsu2dtcm_rsp_ready = rsp_ready_q;
  assign lsu_busy           = busy_q;

endmodule

// File: tb/tb_lsu_dtcm_master.sv
// Directed bench for lsu_dtcm_master: a transaction-level model checks every
// cycle, and literal expectations pin the headline cases.
module tb_lsu_dtcm_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        agu_req_valid = 1'b0;
  logic        agu_req_ready;
  logic        agu_req_load = 1'b0;
  logic [1:0]  agu_req_size = 2'b00;
  logic        agu_req_usign = 1'b0;
  logic [31:0] agu_req_addr = 32'h0;
  logic [31:0] agu_req_wdata = 32'h0;
  logic [4:0]  agu_req_rd = 5'd0;
  logic        lsu_wb_valid;
  logic        lsu_wb_ready = 1'b1;
  logic [31:0] lsu_wb_data;
  logic [4:0]  lsu_wb_rd;
  logic        lsu_wb_err;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic        cmd_read;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid = 1'b1;
  logic        rsp_ready;
  logic [31:0] rsp_rdata = 32'h0;
  logic        lsu_busy;

  always #5 clk = ~clk;

  lsu_dtcm_master #(.AW(32), .DW(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .agu_req_valid      (agu_req_valid),
    .agu_req_ready      (agu_req_ready),
    .agu_req_load       (agu_req_load),
    .agu_req_size       (agu_req_size),
    .agu_req_usign      (agu_req_usign),
    .agu_req_addr       (agu_req_addr),
    .agu_req_wdata      (agu_req_wdata),
    .agu_req_rd         (agu_req_rd),
    .lsu_wb_valid       (lsu_wb_valid),
    .lsu_wb_ready       (lsu_wb_ready),
    .lsu_wb_data        (lsu_wb_data),
    .lsu_wb_rd          (lsu_wb_rd),
    .lsu_wb_err         (lsu_wb_err),
    .lsu2dtcm_cmd_valid (cmd_valid),
    .lsu2dtcm_cmd_ready (cmd_ready),
    .lsu2dtcm_cmd_read  (cmd_read),
    .lsu2dtcm_cmd_addr  (cmd_addr),
    .lsu2dtcm_cmd_wdata (cmd_wdata),
    .lsu2dtcm_cmd_wmask (cmd_wmask),
    .lsu2dtcm_rsp_valid (rsp_valid),
    .lsu2dtcm_rsp_ready (rsp_ready),
    .lsu2dtcm_rsp_rdata (rsp_rdata),
    .lsu_busy           (lsu_busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] b, h;
    b = wd & 32'hFF;
    h = wd & 32'hFFFF;
    if (sz == 2'd0) return b * 32'h0101_0101;
    if (sz == 2'd1) return h * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [3:0] m_wmask(input logic ld, input logic [1:0] sz, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (ld) return 4'h0;
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_load(input logic ld, input logic [1:0] sz, input logic us,
                                         input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] lane, v;
    int off;
    if (!ld) return 32'h0;
    off  = int'(a % 4);
    lane = rd >> (8 * off);
    if (sz == 2'd0) begin
      v = lane & 32'hFF;
      if (!us && v >= 32'h80) v = v | 32'hFFFF_FF00;
      return v;
    end
    if (sz == 2'd1) begin
      v = lane & 32'hFFFF;
      if (!us && v >= 32'h8000) v = v | 32'hFFFF_0000;
      return v;
    end
    return rd;
  endfunction

  // Model: stage 0 idle, 1 awaiting command, 2 awaiting response, 3 completion pending
  int          m_stage = 0;
  logic        m_ld = 1'b0;
  logic [1:0]  m_sz = 2'b00;
  logic        m_us = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wd = 32'h0;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_exp_data = 32'h0;
  logic        m_exp_err = 1'b0;
  logic        prev_rst = 1'b0;
  int          cmd_cnt = 0;
  int          wb_cnt = 0;

  always @(negedge clk) begin : monitor
    int ns;
    logic [11:0] any_out;
    #2;
    ns = m_stage;
    if (rst) begin
      if (prev_rst) begin
        any_out = {agu_req_ready, lsu_wb_valid, |lsu_wb_data, |lsu_wb_rd, lsu_wb_err, cmd_valid,
                   cmd_read, |cmd_addr, |cmd_wdata, |cmd_wmask, rsp_ready, lsu_busy};
        chk("reset_outputs_zero", 32'(any_out), 32'h0);
      end
      ns = 0;
    end else begin
      chk("req_ready", 32'(agu_req_ready), 32'(m_stage == 0 && !prev_rst));
      chk("busy", 32'(lsu_busy), 32'(m_stage != 0));
      chk("cmd_valid", 32'(cmd_valid), 32'(m_stage == 1));
      chk("rsp_ready", 32'(rsp_ready), 32'(m_stage == 2));
      chk("wb_valid", 32'(lsu_wb_valid), 32'(m_stage == 3));
      if (m_stage == 1) begin
        chk("cmd_addr", cmd_addr, m_addr & ~32'h3);
        chk("cmd_read", 32'(cmd_read), 32'(m_ld));
        chk("cmd_wmask", 32'(cmd_wmask), 32'(m_wmask(m_ld, m_sz, m_addr)));
        if (!m_ld) chk("cmd_wdata", cmd_wdata, m_wdata(m_sz, m_wd));
        if (cmd_ready) begin
          ns = 2;
          cmd_cnt++;
        end
      end
      if (m_stage == 2 && rsp_valid) begin
        m_exp_data = m_load(m_ld, m_sz, m_us, m_addr, rsp_rdata);
        m_exp_err  = 1'b0;
        ns = 3;
      end
      if (m_stage == 3) begin
        chk("wb_data", lsu_wb_data, m_exp_data);
        chk("wb_rd", 32'(lsu_wb_rd), 32'(m_rd));
        chk("wb_err", 32'(lsu_wb_err), 32'(m_exp_err));
        if (lsu_wb_ready) begin
          ns = 0;
          wb_cnt++;
        end
      end
      if (m_stage == 0 && !prev_rst && agu_req_valid) begin
        m_ld = agu_req_load; m_sz = agu_req_size; m_us = agu_req_usign;
        m_addr = agu_req_addr; m_wd = agu_req_wdata; m_rd = agu_req_rd;
        if (m_mis(m_sz, m_addr)) begin
          m_exp_data = 32'h0;
          m_exp_err  = 1'b1;
          ns = 3;
        end else begin
          ns = 1;
        end
      end
    end
    m_stage  = ns;
    prev_rst = rst;
  end

  // ---------------- directed driver ----------------
  int          t_acc, t_cmd, t_wb, n_cmds;
  logic [31:0] c_addr, c_wdata, w_data;
  logic [3:0]  c_wmask;
  logic        c_read, w_err;
  logic [4:0]  w_rd;

  // Issue one request (call at posedge+1); stall counts hold ready low that many cycles
  task automatic run(input logic ld, input logic [1:0] sz, input logic us, input logic [31:0] a,
                     input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rword,
                     input int cstall, input int wstall);
    int cs, ws, n;
    logic done;
    cs = 0; ws = 0; n = 0; done = 1'b0;
    t_acc = -1; t_cmd = -1; t_wb = -1; n_cmds = 0;
    rsp_rdata     = rword;
    cmd_ready     = (cstall == 0);
    lsu_wb_ready  = (wstall == 0);
    agu_req_load  = ld;  agu_req_size = sz; agu_req_usign = us;
    agu_req_addr  = a;   agu_req_wdata = wd; agu_req_rd = rd;
    agu_req_valid = 1'b1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (agu_req_valid) begin
        if (t_acc >= 0) agu_req_valid = 1'b0;
        else if (agu_req_ready) t_acc = cyc;
      end
      if (cmd_valid) begin
        if (t_cmd < 0) begin
          t_cmd = cyc; c_addr = cmd_addr; c_read = cmd_read; c_wdata = cmd_wdata; c_wmask = cmd_wmask;
        end
        if (!cmd_ready) begin
          if (cs == cstall) cmd_ready = 1'b1;
          else cs++;
        end
        if (cmd_ready) n_cmds++;
      end
      if (lsu_wb_valid) begin
        if (t_wb < 0) begin
          t_wb = cyc; w_data = lsu_wb_data; w_rd = lsu_wb_rd; w_err = lsu_wb_err;
        end
        if (!lsu_wb_ready) begin
          if (ws == wstall) lsu_wb_ready = 1'b1;
          else ws++;
        end
        if (lsu_wb_ready) done = 1'b1;
      end
    end
    chk("run_completes", 32'(done), 32'h1);
    @(posedge clk);
    #1;
    agu_req_valid = 1'b0;
    cmd_ready     = 1'b1;
    lsu_wb_ready  = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c0, w0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // LW 0x100, always-ready handshakes
    run(1'b1, 2'd2, 1'b0, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0, 0);
    chk("lw_cmd_addr", c_addr, 32'h100);
    chk("lw_cmd_read", 32'(c_read), 32'h1);
    chk("lw_cmd_wmask", 32'(c_wmask), 32'h0);
    chk("lw_cmd_latency", 32'(t_cmd - t_acc), 32'd1);
    chk("lw_wb_latency", 32'(t_wb - t_acc), 32'd3);
    chk("lw_wb_data", w_data, 32'hDEADBEEF);
    chk("lw_wb_rd", 32'(w_rd), 32'd5);

    // LB / LBU 0x103
    run(1'b1, 2'd0, 1'b0, 32'h103, 32'h0, 5'd7, 32'h80112233, 0, 0);
    chk("lb_wb_data", w_data, 32'hFFFFFF80);
    run(1'b1, 2'd0, 1'b1, 32'h103, 32'h0, 5'd7, 32'h80112233, 0, 0);
    chk("lbu_wb_data", w_data, 32'h00000080);

    // SH 0x102; response data must not leak into a store completion
    run(1'b0, 2'd1, 1'b0, 32'h102, 32'h1234ABCD, 5'd9, 32'hFFFFFFFF, 0, 0);
    chk("sh_cmd_addr", c_addr, 32'h100);
    chk("sh_cmd_read", 32'(c_read), 32'h0);
    chk("sh_cmd_wdata", c_wdata, 32'hABCDABCD);
    chk("sh_cmd_wmask", 32'(c_wmask), 32'hC);
    chk("sh_wb_data", w_data, 32'h0);
    chk("sh_wb_err", 32'(w_err), 32'h0);

    // Misaligned LW 0x101: no command, error at T+1
    run(1'b1, 2'd2, 1'b0, 32'h101, 32'h0, 5'd3, 32'h12345678, 0, 0);
    chk("mis_lw_no_cmd", 32'(n_cmds), 32'h0);
    chk("mis_lw_latency", 32'(t_wb - t_acc), 32'd1);
    chk("mis_lw_err", 32'(w_err), 32'h1);
    chk("mis_lw_data", w_data, 32'h0);

    // SB 0x201 with cmd_ready low 3 cycles, wb_ready low 2 cycles
    c0 = cmd_cnt; w0 = wb_cnt;
    run(1'b0, 2'd0, 1'b0, 32'h201, 32'h0000005A, 5'd12, 32'h0, 3, 2);
    chk("sb_cmd_addr", c_addr, 32'h200);
    chk("sb_cmd_wdata", c_wdata, 32'h5A5A5A5A);
    chk("sb_cmd_wmask", 32'(c_wmask), 32'h2);
    chk("stall_one_cmd", 32'(cmd_cnt - c0), 32'd1);
    chk("stall_one_wb", 32'(wb_cnt - w0), 32'd1);
    chk("stall_cmd_to_wb", 32'(t_wb - t_cmd), 32'd5);

    // LH / LHU 0x106 (upper half)
    run(1'b1, 2'd1, 1'b0, 32'h106, 32'h0, 5'd20, 32'h80017FFF, 0, 0);
    chk("lh_wb_data", w_data, 32'hFFFF8001);
    run(1'b1, 2'd1, 1'b1, 32'h106, 32'h0, 5'd21, 32'h80017FFF, 0, 0);
    chk("lhu_wb_data", w_data, 32'h00008001);

    // SW 0x10C with a one-cycle command stall
    run(1'b0, 2'd2, 1'b0, 32'h10C, 32'h11223344, 5'd1, 32'h0, 1, 0);
    chk("sw_cmd_wdata", c_wdata, 32'h11223344);
    chk("sw_cmd_wmask", 32'(c_wmask), 32'hF);

    // size 11 behaves as word
    run(1'b1, 2'd3, 1'b0, 32'h108, 32'h0, 5'd2, 32'h0BADF00D, 0, 0);
    chk("sz3_wb_data", w_data, 32'h0BADF00D);
    run(1'b1, 2'd3, 1'b0, 32'h10A, 32'h0, 5'd2, 32'h0BADF00D, 0, 0);
    chk("sz3_mis_err", 32'(w_err), 32'h1);

    // Misaligned LH, and LB at an odd address
    run(1'b1, 2'd1, 1'b0, 32'h105, 32'h0, 5'd4, 32'h0, 0, 0);
    chk("mis_lh_err", 32'(w_err), 32'h1);
    run(1'b1, 2'd0, 1'b0, 32'h101, 32'h0, 5'd6, 32'h0000FF00, 0, 0);
    chk("lb_odd_data", w_data, 32'hFFFFFFFF);
    chk("lb_odd_err", 32'(w_err), 32'h0);

    // Reset for 2 cycles while a command is stalled; late responses stay high
    cmd_ready = 1'b0;
    rsp_rdata = 32'hCAFEF00D;
    agu_req_load = 1'b1; agu_req_size = 2'd2; agu_req_addr = 32'h100; agu_req_rd = 5'd8;
    agu_req_valid = 1'b1;
    @(posedge clk);
    #1 agu_req_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_cmd_valid", 32'(cmd_valid), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'h0);
    chk("rst_wb_valid", 32'(lsu_wb_valid), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    cmd_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_release_ready", 32'(agu_req_ready), 32'h1);
    @(posedge clk);
    #1;
    c0 = wb_cnt;
    run(1'b1, 2'd2, 1'b0, 32'h100, 32'h0, 5'd11, 32'h600DD00D, 0, 0);
    chk("post_rst_wb_data", w_data, 32'h600DD00D);
    chk("post_rst_one_wb", 32'(wb_cnt - c0), 32'd1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
